gpg_tick_poller: RTL
====================

GPG_TICK_POLLER -- requirements
Module: gpg_tick_poller

Interface
REQ-001 SHALL have parameter G_CLK_FREQ_MHZ, default 50, system clock frequency in MHz (integer).
REQ-002 SHALL have parameter G_POLL_PERIOD_US, default 10000, odometry poll period in us.
REQ-003 SHALL have parameter G_TIMEOUT_US, default 2000, maximum wait for one ticks reply in us.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port enable_i, input, 1 bit: 1 = periodic polling active.
REQ-007 SHALL have port get_motor_ticks_left_o, output, 1 bit: one-cycle request to the SPI controller for left ticks.
REQ-008 SHALL have port get_motor_ticks_rght_o, output, 1 bit: one-cycle request for right ticks.
REQ-009 SHALL have port motor_ticks_left_rdy_i, input, 1 bit: one-cycle strobe, left value valid.
REQ-010 SHALL have port motor_ticks_rght_rdy_i, input, 1 bit: one-cycle strobe, right value valid.
REQ-011 SHALL have ports motor_ticks_left_i and motor_ticks_rght_i, input, 32 bits each: two's-complement tick counts.
REQ-012 SHALL have ports delta_left_o and delta_rght_o, output, 32 bits each: signed tick change since the previous valid sample.
REQ-013 SHALL have port odom_valid_o, output, 1 bit: one-cycle strobe, deltas updated.
REQ-014 SHALL have port timeout_o, output, 1 bit: one-cycle strobe, a reply was not received in time.
REQ-015 SHALL have port overrun_o, output, 1 bit: one-cycle strobe, a period expired while a poll was still in progress.
REQ-016 SHALL have port busy_o, output, 1 bit: 1 whenever the FSM is not IDLE.

Function
REQ-017 Period counter SHALL count 0 .. G_CLK_FREQ_MHZ*G_POLL_PERIOD_US-1 while enable_i=1, emit an internal period tick at the terminal count, wrap to 0, and hold at 0 while enable_i=0.
REQ-018 FSM states SHALL be IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, UPDATE.
REQ-019 IDLE->REQ_L on a period tick; REQ_L SHALL assert get_motor_ticks_left_o for exactly one cycle, then go to WAIT_L.
REQ-020 WAIT_L->REQ_R on motor_ticks_left_rdy_i, capturing motor_ticks_left_i; REQ_R/WAIT_R SHALL behave symmetrically for the right side, then go to UPDATE.
REQ-021 Requests SHALL be strictly serialized: at most one request outstanding; left and right requests never asserted in the same cycle.
REQ-022 A rdy strobe for the side not being waited for SHALL be ignored.
REQ-023 UPDATE SHALL compute delta = captured - previous as a modulo-2^32 subtraction (wrap from 0x7FFFFFFF to 0x80000000 yields +1), store captured values as previous, pulse odom_valid_o for one cycle, and return to IDLE.
REQ-024 The first UPDATE after reset SHALL output deltas of 0 and only initialize the previous values.
REQ-025 Latency SHALL be: odom_valid_o exactly one cycle after the cycle in which motor_ticks_rght_rdy_i is sampled in WAIT_R.
REQ-026 A period tick in any state other than IDLE SHALL pulse overrun_o for one cycle and SHALL be discarded (not queued).
REQ-027 enable_i falling SHALL NOT abort an in-progress poll; it completes normally.
REQ-028 delta outputs SHALL hold their value between odom_valid_o strobes.

Reset
REQ-029 On rst=1 (asynchronous): FSM=IDLE, period counter=0, all strobes=0, busy_o=0, delta_left_o=delta_rght_o=0, previous values=0, first-sample flag set.
REQ-030 Reset asserted mid-poll SHALL abandon the poll with no odom_valid_o, timeout_o or overrun_o pulse.

Configuration
REQ-031 With macro GPG_POLL_TIMEOUT_EN defined: a timeout counter SHALL clear on entry to WAIT_L/WAIT_R, and after G_CLK_FREQ_MHZ*G_TIMEOUT_US cycles without the matching rdy, the FSM SHALL pulse timeout_o, return to IDLE, and leave deltas and previous values unchanged.
REQ-032 Without GPG_POLL_TIMEOUT_EN: WAIT states SHALL wait indefinitely, no timeout counter SHALL be built, and timeout_o SHALL be constant 0.

Verification (G_CLK_FREQ_MHZ=1, G_POLL_PERIOD_US=20, G_TIMEOUT_US=8)
REQ-033 enable_i=1, replies left=100, right=200 three cycles after each request -> first odom_valid_o with deltas 0/0; next poll with 150/180 -> deltas +50/-20.
REQ-034 Previous left=0x7FFFFFFF, new left=0x80000000 -> delta_left_o=0x00000001; previous right=5, new=0xFFFFFFFB -> delta_rght_o=0xFFFFFFF6 (-10).
REQ-035 Right reply withheld, GPG_POLL_TIMEOUT_EN defined -> timeout_o pulses 8 cycles after entering WAIT_R, no odom_valid_o, busy_o=0 next cycle.
REQ-036 Left reply delayed 25 cycles, macro undefined -> overrun_o pulses once at the period tick, poll completes with odom_valid_o, timeout_o never 1.
REQ-037 Spurious motor_ticks_rght_rdy_i in WAIT_L -> ignored, no state change; rst pulsed in WAIT_R -> all outputs 0, next poll is a first sample (deltas 0).

Source files
------------

// File: rtl/gpg_tick_poller.sv
// Periodic odometry poller: requests left then right motor tick counts and
// publishes signed deltas. Optional reply timeout with macro GPG_POLL_TIMEOUT_EN.
module gpg_tick_poller #(
  parameter int G_CLK_FREQ_MHZ   = 50,
  parameter int G_POLL_PERIOD_US = 10000,
  parameter int G_TIMEOUT_US     = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  output logic        get_motor_ticks_left_o,
  output logic        get_motor_ticks_rght_o,
  input  logic        motor_ticks_left_rdy_i,
  input  logic        motor_ticks_rght_rdy_i,
  input  logic [31:0] motor_ticks_left_i,
  input  logic [31:0] motor_ticks_rght_i,
  output logic [31:0] delta_left_o,
  output logic [31:0] delta_rght_o,
  output logic        odom_valid_o,
  output logic        timeout_o,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam logic [31:0] C_PERIOD = 32'(G_CLK_FREQ_MHZ * G_POLL_PERIOD_US);

  if (G_CLK_FREQ_MHZ < 1 || G_POLL_PERIOD_US < 1 || G_TIMEOUT_US < 1)
    $error("gpg_tick_poller: clock, period and timeout parameters must be >= 1");

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_L, S_WAIT_L, S_REQ_R, S_WAIT_R, S_UPDATE
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_per_cnt;
  logic        w_tick;
  logic        w_to_exp;
  logic [31:0] r_cap_left, r_prev_left, r_prev_rght;
  logic [31:0] r_delta_left, r_delta_rght;
  logic        r_first;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_per_cnt <= '0;
    else if (!enable_i)             r_per_cnt <= '0;
    else if (r_per_cnt == C_PERIOD - 32'd1) r_per_cnt <= '0;
    else                            r_per_cnt <= r_per_cnt + 32'd1;
  end

  assign w_tick = enable_i && (r_per_cnt == C_PERIOD - 32'd1);

`ifdef GPG_POLL_TIMEOUT_EN
  localparam logic [31:0] C_TIMEOUT = 32'(G_CLK_FREQ_MHZ * G_TIMEOUT_US);
  logic [31:0] r_to_cnt;

  // Held at 0 outside the wait states, so it starts from 0 on every WAIT entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_to_cnt <= '0;
    else if (r_state == S_WAIT_L || r_state == S_WAIT_R) r_to_cnt <= r_to_cnt + 32'd1;
    else                                            r_to_cnt <= '0;
  end

  assign w_to_exp = (r_to_cnt == C_TIMEOUT - 32'd1) &&
                    ((r_state == S_WAIT_L && !motor_ticks_left_rdy_i) ||
                     (r_state == S_WAIT_R && !motor_ticks_rght_rdy_i));
`else
  assign w_to_exp = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next                 = r_state;
    get_motor_ticks_left_o = 1'b0;
    get_motor_ticks_rght_o = 1'b0;
    odom_valid_o           = 1'b0;
    busy_o                 = (r_state != S_IDLE);
    overrun_o              = w_tick && (r_state != S_IDLE);
    timeout_o              = w_to_exp;
    case (r_state)
      S_IDLE:   if (w_tick) w_next = S_REQ_L;
      S_REQ_L: begin
        get_motor_ticks_left_o = 1'b1;
        w_next                 = S_WAIT_L;
      end
      S_WAIT_L: begin
        if (motor_ticks_left_rdy_i) w_next = S_REQ_R;
        else if (w_to_exp)          w_next = S_IDLE;
      end
      S_REQ_R: begin
        get_motor_ticks_rght_o = 1'b1;
        w_next                 = S_WAIT_R;
      end
      S_WAIT_R: begin
        if (motor_ticks_rght_rdy_i) w_next = S_UPDATE;
        else if (w_to_exp)          w_next = S_IDLE;
      end
      S_UPDATE: begin
        odom_valid_o = 1'b1;
        w_next       = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Deltas are registered on the edge entering UPDATE so they are already
  // valid during the odom_valid_o cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_left   <= '0;
      r_prev_left  <= '0;
      r_prev_rght  <= '0;
      r_delta_left <= '0;
      r_delta_rght <= '0;
      r_first      <= 1'b1;
    end else begin
      if (r_state == S_WAIT_L && motor_ticks_left_rdy_i)
        r_cap_left <= motor_ticks_left_i;
      if (r_state == S_WAIT_R && motor_ticks_rght_rdy_i) begin
        if (r_first) begin
          r_delta_left <= '0;
          r_delta_rght <= '0;
        end else begin
          r_delta_left <= r_cap_left - r_prev_left;
          r_delta_rght <= motor_ticks_rght_i - r_prev_rght;
        end
        r_prev_left <= r_cap_left;
        r_prev_rght <= motor_ticks_rght_i;
        r_first     <= 1'b0;
      end
    end
  end

  assign delta_left_o = r_delta_left;
  assign delta_rght_o = r_delta_rght;

endmodule
